instr_fetch_unit: RTL and testbench

- Front-end stage of the CPU. It owns the fetch address and drives the instruction-memory read port (I_MEM_OE, i_addr_bus).
- It buffers returned 16-bit instruction words in a small prefetch queue. It hands them to the instruction register / control unit through a valid/ready handshake.
- It accepts jump redirects and a halt request from the control unit.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and default widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, instruction
// handshake towards the control unit, and redirect/halt controls.
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              I_MEM_OE;
  logic [ADDR_W-1:0] i_addr_bus;
  logic [DATA_W-1:0] i_data;
  logic              i_mem_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              halt;
  logic              halted;
  logic [ADDR_W-1:0] fetch_pc;

  // Fetch unit side
  modport master (
    output I_MEM_OE, i_addr_bus, instr, instr_pc, instr_valid, halted, fetch_pc,
    input  i_data, i_mem_ready, instr_ready, jump_en, jump_addr, halt
  );

  // Memory / control-unit side
  modport slave (
    input  I_MEM_OE, i_addr_bus, instr, instr_pc, instr_valid, halted, fetch_pc,
    output i_data, i_mem_ready, instr_ready, jump_en, jump_addr, halt
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instruction} entries. Head is read from
// registered storage, so the consumer never sees a path from memory data.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int W     = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output logic [W-1:0]               head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both push and pop; pop is ignored on an empty queue.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count_reg != '0) && !flush;

  // Entry storage: written only on an accepted push, no reset needed
  // because the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  assign head_data  = head_valid ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// CPU front-end: owns the fetch pc, drives the instruction-memory read port,
// buffers returned words and hands them on through a valid/ready handshake.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);

  fetch_state_t               state_reg;
  fetch_state_t               state_next;
  logic [ADDR_W-1:0]          pc_reg;
  logic                       push;
  logic                       pop;
  logic [CNT_W-1:0]           q_count;
  logic [CNT_W-1:0]           count_after;
  logic                       q_valid;
  logic [ADDR_W+DATA_W-1:0]   q_head;

  // Handshake decode and next-state selection; a redirect overrides everything.
  always_comb begin
    pop         = q_valid && bus.instr_ready;
    push        = (state_reg == FETCH) && bus.i_mem_ready && !bus.jump_en;
    count_after = q_count + CNT_W'(push) - CNT_W'(pop);
    state_next  = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.jump_en)          state_next = IDLE;
        else if (bus.halt)        state_next = HALTED;
        else if (q_count < QFULL) state_next = FETCH;
      end
      FETCH: begin
        if (bus.jump_en) begin
          state_next = IDLE;
        end else if (bus.i_mem_ready) begin
          if (bus.halt)                  state_next = HALTED;
          else if (count_after < QFULL)  state_next = FETCH;
          else                           state_next = IDLE;
        end
      end
      HALTED: begin
        // A redirect while halted only moves pc; it does not release the halt.
        if (!bus.jump_en && !bus.halt) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register; async reset drops the read request immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Fetch pc: redirect target, or advance (mod 2^ADDR_W) on each accepted read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           pc_reg <= RESET_PC;
    else if (bus.jump_en) pc_reg <= bus.jump_addr;
    else if (push)        pc_reg <= pc_reg + ADDR_W'(1);
  end

  fetch_queue #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  ({pc_reg, bus.i_data}),
    .pop        (pop),
    .flush      (bus.jump_en),
    .count      (q_count),
    .head_valid (q_valid),
    .head_data  (q_head)
  );

  assign bus.I_MEM_OE    = (state_reg == FETCH);
  assign bus.i_addr_bus  = pc_reg;
  assign bus.fetch_pc    = pc_reg;
  assign bus.halted      = (state_reg == HALTED);
  assign bus.instr_valid = q_valid;
  assign bus.instr       = q_head[DATA_W-1:0];
  assign bus.instr_pc    = q_head[ADDR_W+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random-latency memory model, directed scenarios
// and a randomized phase, checked by a stream scoreboard. The reference model
// says the consumer sees mem[a], mem[a+1], ... starting at RESET_PC or at the
// latest redirect target, and that reads are issued in that same order.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  instr_fetch_unit #(
    .ADDR_W(8), .DATA_W(16), .QDEPTH(2), .RESET_PC(8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [256];
  int          total = 0;
  int          bad = 0;
  int          reads = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  bit          rand_lat = 1'b0;
  logic [23:0] exp_q [$];
  logic [7:0]  model_next;
  logic [7:0]  fetch_exp;
  bit          prev_pend = 1'b0;
  logic [7:0]  prev_addr;

  assign bus.i_data = mem[bus.i_addr_bus];

  task automatic check(input string name, input int unsigned act, input int unsigned want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic void sb_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({model_next, mem[model_next]});
      model_next = model_next + 8'd1;
    end
  endfunction

  function automatic void sb_restart(input logic [7:0] a);
    exp_q.delete();
    model_next = a;
    fetch_exp  = a;
    sb_fill();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Redirect for one cycle; the consumer is held off in that cycle.
  task automatic do_jump(input logic [7:0] a);
    logic saved;
    saved           = bus.instr_ready;
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b1;
    bus.jump_addr   = a;
    sb_restart(a);
    tick();
    bus.jump_en     = 1'b0;
    bus.instr_ready = saved;
  endtask

  task automatic wait_oe();
    int n = 0;
    while (!bus.I_MEM_OE && n < 20) begin
      tick();
      n++;
    end
    check("wait_oe", bus.I_MEM_OE, 1);
  endtask

  // Memory model: answers each read after `lat` wait cycles.
  always begin
    @(posedge clk);
    #1;
    if (!bus.I_MEM_OE) begin
      wait_cnt = 0;
      bus.i_mem_ready = 1'b0;
    end else begin
      bus.i_mem_ready = (wait_cnt >= lat);
      if (bus.i_mem_ready) begin
        wait_cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 2);
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor: scoreboard pops, read-order checks and request stability.
  always @(negedge clk) begin
    logic [23:0] e;
    if (!reset) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        check("hold_oe", bus.I_MEM_OE, 1);
        check("hold_addr", bus.i_addr_bus, prev_addr);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          $display("pop pc=%02h instr=%04h", bus.instr_pc, bus.instr);
          check("instr_pc", bus.instr_pc, e[23:16]);
          check("instr", bus.instr, e[15:0]);
          sb_fill();
        end
      end
      if (bus.I_MEM_OE && bus.i_mem_ready && !bus.jump_en) begin
        check("fetch_addr", bus.i_addr_bus, fetch_exp);
        fetch_exp = fetch_exp + 8'd1;
        reads++;
      end
      prev_pend = bus.I_MEM_OE && !bus.i_mem_ready && !bus.jump_en;
      prev_addr = bus.i_addr_bus;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    reset           = 1'b0;
    bus.i_mem_ready = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_en     = 1'b0;
    bus.jump_addr   = 8'h00;
    bus.halt        = 1'b0;
    sb_restart(8'h00);
    repeat (3) tick();

    // Reset values
    check("rst_oe", bus.I_MEM_OE, 0);
    check("rst_addr", bus.i_addr_bus, 8'h00);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_fetch_pc", bus.fetch_pc, 0);

    // Zero-wait memory, free consumer: back-to-back reads, one per cycle
    bus.instr_ready = 1'b1;
    reset = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("b2b_oe", bus.I_MEM_OE, 1);
      check("b2b_addr", bus.i_addr_bus, k);
      if (k > 0) begin
        check("b2b_valid", bus.instr_valid, 1);
        check("b2b_instr_pc", bus.instr_pc, k - 1);
      end
      tick();
    end

    // Stalled consumer: queue fills after exactly two reads
    reset = 1'b0;
    bus.instr_ready = 1'b0;
    sb_restart(8'h00);
    reads = 0;
    tick();
    reset = 1'b1;
    repeat (6) tick();
    check("full_oe", bus.I_MEM_OE, 0);
    check("full_valid", bus.instr_valid, 1);
    check("full_instr_pc", bus.instr_pc, 8'h00);
    check("full_fetch_pc", bus.fetch_pc, 8'h02);
    check("full_reads", reads, 2);
    bus.instr_ready = 1'b1;
    wait_oe();
    check("resume_addr", bus.i_addr_bus, 8'h02);

    // Slow memory: request held for four cycles, one push
    bus.instr_ready = 1'b0;
    lat = 3;
    do_jump(8'h05);
    wait_oe();
    for (int i = 0; i < 4; i++) begin
      check("slow_oe", bus.I_MEM_OE, 1);
      check("slow_addr", bus.i_addr_bus, 8'h05);
      tick();
    end
    check("slow_valid", bus.instr_valid, 1);
    check("slow_instr_pc", bus.instr_pc, 8'h05);
    check("slow_fetch_pc", bus.fetch_pc, 8'h06);
    lat = 0;
    bus.instr_ready = 1'b1;

    // Redirect in the same cycle as a read response: response dropped
    do_jump(8'h07);
    tick();
    check("jr_oe", bus.I_MEM_OE, 1);
    check("jr_addr", bus.i_addr_bus, 8'h07);
    do_jump(8'h40);
    check("jr_valid", bus.instr_valid, 0);
    check("jr_oe_off", bus.I_MEM_OE, 0);
    check("jr_fetch_pc", bus.fetch_pc, 8'h40);
    tick();
    check("jr_new_oe", bus.I_MEM_OE, 1);
    check("jr_new_addr", bus.i_addr_bus, 8'h40);

    // Wrap at 0xFF and halt raised while a read is outstanding
    bus.instr_ready = 1'b0;
    lat = 2;
    do_jump(8'hFF);
    wait_oe();
    check("halt_addr", bus.i_addr_bus, 8'hFF);
    bus.halt = 1'b1;
    tick();
    check("halt_wait_oe", bus.I_MEM_OE, 1);
    check("halt_wait_halted", bus.halted, 0);
    tick();
    check("halt_wait_oe2", bus.I_MEM_OE, 1);
    tick();
    check("halted", bus.halted, 1);
    check("halted_oe", bus.I_MEM_OE, 0);
    check("wrap_fetch_pc", bus.fetch_pc, 8'h00);
    check("halted_valid", bus.instr_valid, 1);
    check("halted_instr_pc", bus.instr_pc, 8'hFF);
    bus.instr_ready = 1'b1;
    tick();
    check("drain_valid", bus.instr_valid, 0);
    check("drain_halted", bus.halted, 1);
    check("drain_oe", bus.I_MEM_OE, 0);
    bus.halt = 1'b0;
    tick();
    check("unhalt_halted", bus.halted, 0);
    check("unhalt_oe", bus.I_MEM_OE, 0);
    tick();
    check("unhalt_fetch_oe", bus.I_MEM_OE, 1);
    check("unhalt_addr", bus.i_addr_bus, 8'h00);

    // Reset in the middle of a read
    bus.instr_ready = 1'b0;
    lat = 1;
    do_jump(8'h33);
    wait_oe();
    repeat (2) tick();
    check("pre_rst_valid", bus.instr_valid, 1);
    check("pre_rst_oe", bus.I_MEM_OE, 1);
    reset = 1'b0;
    #1;
    check("async_oe", bus.I_MEM_OE, 0);
    check("async_valid", bus.instr_valid, 0);
    check("async_fetch_pc", bus.fetch_pc, 8'h00);
    check("async_halted", bus.halted, 0);
    sb_restart(8'h00);
    lat = 0;
    bus.instr_ready = 1'b1;
    tick();
    reset = 1'b1;
    wait_oe();
    check("rst_restart_addr", bus.i_addr_bus, 8'h00);

    // Randomized traffic: consumer stalls, halts, redirects, random latency
    rand_lat = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) bus.halt = !bus.halt;
      if ($urandom_range(0, 39) == 0) do_jump(8'($urandom_range(0, 255)));
      else tick();
    end
    bus.halt = 1'b0;
    rand_lat = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
